nco_voice_allocator: RTL and testbench
======================================

Name: nco_voice_allocator

Overview:
- Polyphonic voice controller for a bank of NUM_VOICES NCO voices.
- Accepts note-on/note-off events over a valid/ready handshake.
- Assigns each note to a voice: retrigger, then free, then oldest-steal.
- Sequences the voice's frequency and amplitude register loads on a shared config bus, then drives per-voice key_on.

Parameters:
NUM_VOICES, 4, number of NCO voices controlled (2..16)
FW, 24, frequency tuning word width
AW, 16, amplitude word width
NOTE_W, 7, note number width (MIDI-style)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
ev_valid  in  1  event present
ev_ready  out  1  allocator can accept event
ev_on  in  1  1 = note-on, 0 = note-off
ev_note  in  NOTE_W  note number
ev_freq  in  FW  tuning word (used on note-on only)
ev_amp  in  AW  amplitude (used on note-on only)
cfg_F  out  FW  shared frequency bus to all voices
cfg_A  out  AW  shared amplitude bus to all voices
loadF  out  NUM_VOICES  one-hot frequency load strobe
loadA  out  NUM_VOICES  one-hot amplitude load strobe
key_on  out  NUM_VOICES  per-voice gate
steal  out  1  one-cycle pulse when an active voice is stolen
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0 except ev_ready = 1. Internal note/age/active tables are cleared; state = IDLE.
- Reset asserted mid-sequence aborts the sequence at once. No load strobe fires in the reset cycle or the cycle after it.
- States: IDLE, SEARCH, LOAD_F, LOAD_A.
- IDLE:
  - ev_ready = 1.
  - A handshake (ev_valid & ev_ready) latches ev_on, ev_note, ev_freq and ev_amp, then moves to SEARCH.
  - ev_ready is 0 in every other state.
- SEARCH (1 cycle), voice selection for note-on, in priority order:
  1. an active voice holding the same note (retrigger);
  2. the lowest-index inactive voice;
  3. the active voice with the largest age (ties go to the lowest index). steal pulses in this same SEARCH cycle.
  - Note-on then moves to LOAD_F.
- SEARCH, note-off:
  - Lowest-index active voice with matching note: clear its key_on and active bit next cycle, then go to IDLE.
  - No match: event is dropped, go to IDLE.
- LOAD_F (1 cycle): cfg_F = latched freq, loadF[v] = 1. Next state LOAD_A.
- LOAD_A (1 cycle): cfg_A = latched amp, loadA[v] = 1.
  - Next cycle: key_on[v] = 1, active[v] = 1, note[v] = latched note, age[v] = 0. Go to IDLE.
- Retrigger and steal keep key_on[v] high throughout.
- cfg_F and cfg_A hold their last driven value when no strobe is active.
- Latency: note-on handshake to key_on high = 4 cycles. Note-off handshake to key_on low = 2 cycles. Back-to-back throughput: one note-on per 4 cycles.
- Age:
  - Per voice, log2(NUM_VOICES)+4 bits, saturating.
  - At each note-on commit, every other active voice's age increments by 1 (saturating).
  - Inactive voices hold age 0.
- At most one bit of loadF/loadA is set in any cycle, and never both vectors in the same cycle.

Optional Feature:
- Macro: NCO_VOICE_ALLOC_SUSTAIN_EN.
- When defined:
  - Adds input port sustain (1 bit).
  - A note-off matching a voice while sustain = 1 sets pending[v] instead of clearing key_on.
  - On the sustain 1->0 edge (registered), all pending voices clear key_on, active and pending in one cycle. This happens even when state != IDLE.
  - A retrigger of a pending voice clears pending[v].
  - Pending voices remain steal candidates as normal.
- When undefined: no sustain port; note-off behaves as above.

Decomposition:
- Package nco_voice_pkg:
  - alloc_state_t enum (IDLE, SEARCH, LOAD_F, LOAD_A);
  - default width constants FW_DEF = 24, AW_DEF = 16, NOTE_W_DEF = 7;
  - function clog2_safe for the index width.
- One sub-module, voice_picker: combinational selection from active, note table, age table and request note. It outputs a voice index plus hit/free/steal flags, and is parameterized by NUM_VOICES.

Test Plan:
- Reset, then note-on note 60, freq 0x00A3D7, amp 0x4000 -> voice 0. loadF[0] at handshake+2 with cfg_F = 0x00A3D7. loadA[0] at +3 with cfg_A = 0x4000. key_on = 4'b0001 at +4.
- Note-on notes 60, 62, 64, 67, then 69 -> voices 0..3 filled. Note 69 steals voice 0 (age 3), steal pulses once, key_on stays 4'b1111.
- Note-on 60, then note-on 60 again with amp 0x2000 -> retrigger of voice 0, no steal, voice 1 untouched.
- Note-off 62 when 62 is not active -> no strobes, key_on unchanged. Note-off 60 -> key_on[0] low 2 cycles after handshake.
- Reset asserted during LOAD_F -> following cycles show loadF = loadA = 0, key_on = 0, ev_ready = 1.
- (SUSTAIN_EN) sustain = 1, note-on 60, note-off 60 -> key_on[0] stays 1. Sustain drops to 0 -> key_on[0] low within 2 cycles.

Source files
------------

// File: rtl/nco_voice_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nco_voice_pkg
// Brief    : Shared types, default widths and index-width helper for the
//            NCO voice allocator.
// Revision : 1.0 - initial release
// ============================================================================
package nco_voice_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOAD_F = 2'd2,
        LOAD_A = 2'd3
    } alloc_state_t;

    localparam int FW_DEF     = 24;
    localparam int AW_DEF     = 16;
    localparam int NOTE_W_DEF = 7;

    // Index width that never collapses to zero bits.
    function automatic int clog2_safe(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_voice_allocator_voice_picker.sv
`default_nettype none
// ============================================================================
// Module   : voice_picker
// Brief    : Combinational voice selection: retrigger, then lowest free,
//            then oldest active voice (ties to lowest index).
// Revision : 1.0 - initial release
// ============================================================================
module voice_picker
    import nco_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = NOTE_W_DEF,
    parameter int AGE_W      = 6,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_VOICES-1:0]             i_active,
    input  logic [NUM_VOICES-1:0][NOTE_W-1:0] i_notes,
    input  logic [NUM_VOICES-1:0][AGE_W-1:0]  i_ages,
    input  logic [NOTE_W-1:0]                 i_req_note,
    output logic [IDX_W-1:0]                  o_idx,
    output logic                              o_hit,
    output logic                              o_free,
    output logic                              o_steal
);

    logic [IDX_W-1:0] w_hit_idx;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_old_idx;
    logic [AGE_W-1:0] w_old_age;

    always_comb begin
        o_hit      = 1'b0;
        o_free     = 1'b0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        // Descending scan so the lowest matching index is the last write.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (i_active[i] && (i_notes[i] == i_req_note)) begin
                o_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!i_active[i]) begin
                o_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end

        w_old_idx = '0;
        w_old_age = i_ages[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (i_ages[i] > w_old_age) begin
                w_old_age = i_ages[i];
                w_old_idx = IDX_W'(i);
            end
        end

        o_steal = !o_hit && !o_free;
        if (o_hit)       o_idx = w_hit_idx;
        else if (o_free) o_idx = w_free_idx;
        else             o_idx = w_old_idx;
    end

endmodule
`default_nettype wire

// File: rtl/nco_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : nco_voice_allocator
// Brief    : Polyphonic note-to-voice allocator sequencing frequency and
//            amplitude loads on a shared bus, then gating key_on.
//            Optional sustain pedal: define NCO_VOICE_ALLOC_SUSTAIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nco_voice_allocator
    import nco_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int FW         = FW_DEF,
    parameter int AW         = AW_DEF,
    parameter int NOTE_W     = NOTE_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
`ifdef NCO_VOICE_ALLOC_SUSTAIN_EN
    input  logic                  sustain,
`endif
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [NOTE_W-1:0]     ev_note,
    input  logic [FW-1:0]         ev_freq,
    input  logic [AW-1:0]         ev_amp,
    output logic [FW-1:0]         cfg_F,
    output logic [AW-1:0]         cfg_A,
    output logic [NUM_VOICES-1:0] loadF,
    output logic [NUM_VOICES-1:0] loadA,
    output logic [NUM_VOICES-1:0] key_on,
    output logic                  steal,
    output logic                  busy
);

    localparam int                 c_idx_w   = clog2_safe(NUM_VOICES);
    localparam int                 c_age_w   = c_idx_w + 4;
    localparam logic [c_age_w-1:0] c_age_max = '1;

    alloc_state_t                        r_state, w_state_nxt;
    logic                                r_on;
    logic [NOTE_W-1:0]                   r_note;
    logic [FW-1:0]                       r_freq, r_cfg_f;
    logic [AW-1:0]                       r_amp, r_cfg_a;
    logic [c_idx_w-1:0]                  r_voice;
    logic [NUM_VOICES-1:0]               r_key_on, r_active;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]   r_note_tab;
    logic [NUM_VOICES-1:0][c_age_w-1:0]  r_age;

    logic [c_idx_w-1:0]    w_pick_idx;
    logic                  w_pick_hit, w_pick_free, w_pick_steal;
    logic [NUM_VOICES-1:0] w_voice_oh, w_pick_oh;
    logic                  w_commit, w_noteoff_hit, w_hold;
    logic [NUM_VOICES-1:0] w_noteoff_clr, w_release_mask;

    voice_picker #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W),
        .AGE_W      (c_age_w),
        .IDX_W      (c_idx_w)
    ) u_picker (
        .i_active   (r_active),
        .i_notes    (r_note_tab),
        .i_ages     (r_age),
        .i_req_note (r_note),
        .o_idx      (w_pick_idx),
        .o_hit      (w_pick_hit),
        .o_free     (w_pick_free),
        .o_steal    (w_pick_steal)
    );

    always_comb begin
        w_voice_oh = '0;
        w_pick_oh  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_voice_oh[i] = (r_voice == c_idx_w'(i));
            w_pick_oh[i]  = (w_pick_idx == c_idx_w'(i));
        end
    end

    assign w_commit      = (r_state == LOAD_A);
    assign w_noteoff_hit = (r_state == SEARCH) && !r_on && w_pick_hit;
    assign w_noteoff_clr = (w_noteoff_hit && !w_hold) ? w_pick_oh : '0;

`ifdef NCO_VOICE_ALLOC_SUSTAIN_EN
    logic [NUM_VOICES-1:0] r_pending;
    logic                  r_sustain_q;

    assign w_hold         = sustain;
    assign w_release_mask = (r_sustain_q && !sustain) ? r_pending : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pending   <= '0;
            r_sustain_q <= 1'b0;
        end else begin
            r_sustain_q <= sustain;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if ((w_commit && w_voice_oh[i]) || w_release_mask[i] || w_noteoff_clr[i])
                    r_pending[i] <= 1'b0;
                else if (w_noteoff_hit && w_hold && w_pick_oh[i])
                    r_pending[i] <= 1'b1;
            end
        end
    end
`else
    assign w_hold         = 1'b0;
    assign w_release_mask = '0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_on       <= 1'b0;
            r_note     <= '0;
            r_freq     <= '0;
            r_amp      <= '0;
            r_voice    <= '0;
            r_cfg_f    <= '0;
            r_cfg_a    <= '0;
            r_key_on   <= '0;
            r_active   <= '0;
            r_note_tab <= '0;
            r_age      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && ev_valid) begin
                r_on   <= ev_on;
                r_note <= ev_note;
                r_freq <= ev_freq;
                r_amp  <= ev_amp;
            end
            if (r_state == SEARCH && (w_pick_hit || w_pick_free || w_pick_steal))
                r_voice <= w_pick_idx;
            if (r_state == SEARCH && r_on)
                r_cfg_f <= r_freq;
            if (r_state == LOAD_F)
                r_cfg_a <= r_amp;
            // A release on another voice outranks the age bump of the same commit.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (w_commit && w_voice_oh[i]) begin
                    r_key_on[i]   <= 1'b1;
                    r_active[i]   <= 1'b1;
                    r_note_tab[i] <= r_note;
                    r_age[i]      <= '0;
                end else if (w_noteoff_clr[i] || w_release_mask[i]) begin
                    r_key_on[i] <= 1'b0;
                    r_active[i] <= 1'b0;
                    r_age[i]    <= '0;
                end else if (w_commit && r_active[i] && (r_age[i] != c_age_max)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        loadF       = '0;
        loadA       = '0;
        steal       = 1'b0;
        ev_ready    = (r_state == IDLE);
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE:    if (ev_valid) w_state_nxt = SEARCH;
            SEARCH:  w_state_nxt = r_on ? LOAD_F : IDLE;
            LOAD_F:  w_state_nxt = LOAD_A;
            LOAD_A:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Strobes are masked while Reset is high so an aborted sequence never loads.
        if (!Reset) begin
            if (r_state == LOAD_F) loadF = w_voice_oh;
            if (r_state == LOAD_A) loadA = w_voice_oh;
            steal = (r_state == SEARCH) && r_on && w_pick_steal;
        end
    end

    assign cfg_F  = r_cfg_f;
    assign cfg_A  = r_cfg_a;
    assign key_on = r_key_on;

endmodule
`default_nettype wire

// File: tb/tb_nco_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_voice_allocator
// Brief    : Directed self-checking bench for nco_voice_allocator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_voice_allocator;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ev_valid, ev_ready, ev_on;
    logic [6:0]  ev_note;
    logic [23:0] ev_freq, cfg_F;
    logic [15:0] ev_amp, cfg_A;
    logic [3:0]  loadF, loadA, key_on;
    logic        steal, busy;
`ifdef NCO_VOICE_ALLOC_SUSTAIN_EN
    logic        sustain;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0]  obs_lf, obs_la, obs_ko, obs_ko_and, obs_stray, obs_ko1, obs_ko2;
    logic [23:0] obs_cf;
    logic [15:0] obs_ca;
    logic        obs_rdy0, obs_rdy_or;
    int          obs_steal;

    nco_voice_allocator #(
        .NUM_VOICES (4),
        .FW         (24),
        .AW         (16),
        .NOTE_W     (7)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
`ifdef NCO_VOICE_ALLOC_SUSTAIN_EN
        .sustain  (sustain),
`endif
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_on    (ev_on),
        .ev_note  (ev_note),
        .ev_freq  (ev_freq),
        .ev_amp   (ev_amp),
        .cfg_F    (cfg_F),
        .cfg_A    (cfg_A),
        .loadF    (loadF),
        .loadA    (loadA),
        .key_on   (key_on),
        .steal    (steal),
        .busy     (busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
    endtask

    // Note-on; returns in the cycle where key_on should have risen (handshake + 4).
    task automatic send_on(input logic [6:0] note, input logic [23:0] freq, input logic [15:0] amp);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = note; ev_freq = freq; ev_amp = amp;
        obs_rdy0 = ev_ready;
        tick();
        ev_valid = 1'b0;
        obs_steal = int'(steal); obs_ko_and = key_on; obs_rdy_or = ev_ready;
        obs_stray = loadF | loadA;
        tick();
        obs_lf = loadF; obs_cf = cfg_F; obs_stray |= loadA;
        obs_steal += int'(steal); obs_ko_and &= key_on; obs_rdy_or |= ev_ready;
        tick();
        obs_la = loadA; obs_ca = cfg_A; obs_stray |= loadF;
        obs_steal += int'(steal); obs_ko_and &= key_on; obs_rdy_or |= ev_ready;
        tick();
        obs_ko = key_on; obs_stray |= loadF | loadA;
        obs_steal += int'(steal); obs_ko_and &= key_on;
    endtask

    // Note-off; returns two cycles after the handshake.
    task automatic send_off(input logic [6:0] note);
        ev_valid = 1'b1; ev_on = 1'b0; ev_note = note;
        tick();
        ev_valid = 1'b0;
        obs_ko1 = key_on; obs_stray = loadF | loadA;
        tick();
        obs_ko2 = key_on; obs_stray |= loadF | loadA; obs_rdy0 = ev_ready;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (ev_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ev_ready); else n_pass++;
        n_total++; if (key_on !== 4'b0000) $display("FAIL reset_key_on: got %b want 0000", key_on); else n_pass++;
        n_total++; if ({loadF, loadA} !== 8'h00) $display("FAIL reset_loads: got %b want 00000000", {loadF, loadA}); else n_pass++;
        n_total++; if ({busy, steal} !== 2'b00) $display("FAIL reset_busy_steal: got %b want 00", {busy, steal}); else n_pass++;
        n_total++; if ({cfg_F, cfg_A} !== 40'h0) $display("FAIL reset_cfg: got %h want 0", {cfg_F, cfg_A}); else n_pass++;
    endtask

    task automatic test_first_note();
        send_on(7'd60, 24'h00A3D7, 16'h4000);
        n_total++; if (obs_rdy0 !== 1'b1) $display("FAIL first_ready: got %b want 1", obs_rdy0); else n_pass++;
        n_total++; if (obs_rdy_or !== 1'b0) $display("FAIL first_ready_busy: got %b want 0", obs_rdy_or); else n_pass++;
        n_total++; if (obs_lf !== 4'b0001) $display("FAIL first_loadF: got %b want 0001", obs_lf); else n_pass++;
        n_total++; if (obs_cf !== 24'h00A3D7) $display("FAIL first_cfg_F: got %h want 00a3d7", obs_cf); else n_pass++;
        n_total++; if (obs_la !== 4'b0001) $display("FAIL first_loadA: got %b want 0001", obs_la); else n_pass++;
        n_total++; if (obs_ca !== 16'h4000) $display("FAIL first_cfg_A: got %h want 4000", obs_ca); else n_pass++;
        n_total++; if (obs_stray !== 4'b0000) $display("FAIL first_stray_strobe: got %b want 0000", obs_stray); else n_pass++;
        n_total++; if (obs_ko !== 4'b0001) $display("FAIL first_key_on: got %b want 0001", obs_ko); else n_pass++;
        n_total++; if (obs_ko_and !== 4'b0000) $display("FAIL first_key_on_early: got %b want 0000", obs_ko_and); else n_pass++;
        n_total++; if ({busy, ev_ready, cfg_F} !== {2'b01, 24'h00A3D7}) $display("FAIL first_idle_hold: got %h want %h", {busy, ev_ready, cfg_F}, {2'b01, 24'h00A3D7}); else n_pass++;
    endtask

    task automatic test_steal();
        do_reset();
        send_on(7'd60, 24'h000100, 16'h1000);
        send_on(7'd62, 24'h000200, 16'h1100);
        n_total++; if (obs_lf !== 4'b0010) $display("FAIL fill_62_loadF: got %b want 0010", obs_lf); else n_pass++;
        send_on(7'd64, 24'h000300, 16'h1200);
        send_on(7'd67, 24'h000400, 16'h1300);
        n_total++; if (obs_la !== 4'b1000) $display("FAIL fill_67_loadA: got %b want 1000", obs_la); else n_pass++;
        n_total++; if (obs_steal !== 0) $display("FAIL fill_67_steal: got %0d want 0", obs_steal); else n_pass++;
        n_total++; if (obs_ko !== 4'b1111) $display("FAIL fill_key_on: got %b want 1111", obs_ko); else n_pass++;
        send_on(7'd69, 24'h000500, 16'h1400);
        n_total++; if (obs_lf !== 4'b0001) $display("FAIL steal_loadF: got %b want 0001", obs_lf); else n_pass++;
        n_total++; if (obs_cf !== 24'h000500) $display("FAIL steal_cfg_F: got %h want 000500", obs_cf); else n_pass++;
        n_total++; if (obs_steal !== 1) $display("FAIL steal_pulses: got %0d want 1", obs_steal); else n_pass++;
        n_total++; if (obs_ko_and !== 4'b1111) $display("FAIL steal_key_hold: got %b want 1111", obs_ko_and); else n_pass++;
        // v0 now youngest; oldest is v1 (age 3).
        send_on(7'd71, 24'h000600, 16'h1500);
        n_total++; if (obs_lf !== 4'b0010) $display("FAIL steal2_loadF: got %b want 0010", obs_lf); else n_pass++;
    endtask

    task automatic test_retrigger();
        do_reset();
        send_on(7'd60, 24'h00A3D7, 16'h4000);
        send_on(7'd60, 24'h00A3D7, 16'h2000);
        n_total++; if (obs_la !== 4'b0001) $display("FAIL retrig_loadA: got %b want 0001", obs_la); else n_pass++;
        n_total++; if (obs_ca !== 16'h2000) $display("FAIL retrig_cfg_A: got %h want 2000", obs_ca); else n_pass++;
        n_total++; if (obs_steal !== 0) $display("FAIL retrig_steal: got %0d want 0", obs_steal); else n_pass++;
        n_total++; if (obs_ko_and !== 4'b0001) $display("FAIL retrig_key_hold: got %b want 0001", obs_ko_and); else n_pass++;
        n_total++; if (obs_ko !== 4'b0001) $display("FAIL retrig_key_on: got %b want 0001", obs_ko); else n_pass++;
    endtask

    task automatic test_note_off();
        send_off(7'd62);
        n_total++; if (obs_stray !== 4'b0000) $display("FAIL off_miss_strobe: got %b want 0000", obs_stray); else n_pass++;
        n_total++; if (obs_ko2 !== 4'b0001) $display("FAIL off_miss_key_on: got %b want 0001", obs_ko2); else n_pass++;
        send_off(7'd60);
        n_total++; if (obs_ko1 !== 4'b0001) $display("FAIL off_hit_early: got %b want 0001", obs_ko1); else n_pass++;
        n_total++; if (obs_ko2 !== 4'b0000) $display("FAIL off_hit_key_on: got %b want 0000", obs_ko2); else n_pass++;
        n_total++; if (obs_rdy0 !== 1'b1) $display("FAIL off_back_idle: got %b want 1", obs_rdy0); else n_pass++;
        // Freed voice 0 is the lowest inactive voice again.
        send_on(7'd64, 24'h00BEEF, 16'h0123);
        n_total++; if (obs_lf !== 4'b0001) $display("FAIL off_reuse_loadF: got %b want 0001", obs_lf); else n_pass++;
    endtask

    task automatic test_reset_mid();
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd70; ev_freq = 24'h123456; ev_amp = 16'h7777;
        tick();
        ev_valid = 1'b0;
        tick();
        n_total++; if (loadF !== 4'b0010) $display("FAIL mid_pre_loadF: got %b want 0010", loadF); else n_pass++;
        Reset = 1'b1;
        #1;
        n_total++; if ({loadF, loadA} !== 8'h00) $display("FAIL mid_reset_cycle_loads: got %b want 00000000", {loadF, loadA}); else n_pass++;
        tick();
        Reset = 1'b0;
        #1;
        n_total++; if ({loadF, loadA} !== 8'h00) $display("FAIL mid_after_loads: got %b want 00000000", {loadF, loadA}); else n_pass++;
        n_total++; if (key_on !== 4'b0000) $display("FAIL mid_after_key_on: got %b want 0000", key_on); else n_pass++;
        n_total++; if (ev_ready !== 1'b1) $display("FAIL mid_after_ready: got %b want 1", ev_ready); else n_pass++;
        tick();
        n_total++; if ({loadF, loadA, key_on} !== 12'h000) $display("FAIL mid_later: got %b want 000000000000", {loadF, loadA, key_on}); else n_pass++;
    endtask

`ifdef NCO_VOICE_ALLOC_SUSTAIN_EN
    task automatic test_sustain();
        do_reset();
        sustain = 1'b1;
        send_on(7'd60, 24'h00A3D7, 16'h4000);
        send_off(7'd60);
        n_total++; if (obs_ko2 !== 4'b0001) $display("FAIL sus_held: got %b want 0001", obs_ko2); else n_pass++;
        repeat (2) tick();
        n_total++; if (key_on !== 4'b0001) $display("FAIL sus_still_held: got %b want 0001", key_on); else n_pass++;
        sustain = 1'b0;
        repeat (2) tick();
        n_total++; if (key_on !== 4'b0000) $display("FAIL sus_release: got %b want 0000", key_on); else n_pass++;
    endtask
`endif

    initial begin
        Reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_freq = '0; ev_amp = '0;
`ifdef NCO_VOICE_ALLOC_SUSTAIN_EN
        sustain = 1'b0;
`endif
        test_reset();
        test_first_note();
        test_steal();
        test_retrigger();
        test_note_off();
        test_reset_mid();
`ifdef NCO_VOICE_ALLOC_SUSTAIN_EN
        test_sustain();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
